sonar_ranger: RTL and testbench
===============================

# sonar_ranger

Ultrasonic ranging engine feeding the display/UART path of `Module_Top`. Fires a periodic trigger pulse on `sonartrigger`, times the returning `sonarecho` pulse and converts its width to millimetres at 6 µs/mm. Reports one distance word per measurement cycle with a valid strobe, or an error strobe when no echo arrives or the echo is over-range.

## Interface
- `CLK_FREQ`, 12_000_000: clock frequency in Hz. Must be an integer multiple of 1 MHz.
- `TRIG_US`, 10: trigger pulse width in µs.
- `PERIOD_MS`, 100: trigger-to-trigger period in ms.
- `US_PER_MM`, 6: echo µs per millimetre.
- `ECHO_WAIT_US`, 30_000: maximum time from trigger fall to echo rise.
- `MAX_MM`, 4000: over-range limit in mm.
- `DIST_W`, 13: width of the distance output.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sonarecho`  in  1  echo from the sensor; asynchronous, synchronised internally.
- `sonartrigger`  out  1  trigger pulse to the sensor.
- `distance_mm`  out  DIST_W  last measured distance; held until the next result.
- `dist_valid`  out  1  one-cycle strobe when `distance_mm` is updated with a good result.
- `dist_error`  out  1  one-cycle strobe on timeout or over-range.
- `busy`  out  1  high from trigger start until result strobe.

## Operation
- Tick generation:
  - µs tick every CLK_FREQ/1e6 clocks (12 at default).
  - ms tick every 1000 µs ticks.
- Echo input:
  - 2-flop synchroniser.
  - Rise and fall detect on the synchronised signal only.
- Period counter:
  - Free-running in ms and independent of the FSM; sets `period_due` on wrap.
  - `period_due` is cleared when the FSM enters TRIG.
  - If the FSM is not in IDLE when the period wraps, the trigger is deferred until IDLE. Periods are never queued beyond one.
- FSM states:
  - IDLE: enter TRIG when `period_due`.
  - TRIG: `sonartrigger`=1 for TRIG_US µs ticks, then go to WAIT_ECHO.
  - WAIT_ECHO: a synchronised rising edge goes to MEASURE. ECHO_WAIT_US elapsed goes to DONE with error. An echo already high on entry is ignored; only an edge starts a measurement.
  - MEASURE:
    - On echo rise, clear the µs prescaler, the mm sub-counter and the mm counter.
    - The mm counter increments every US_PER_MM µs ticks.
    - Echo fall goes to DONE, good.
    - mm counter reaching MAX_MM goes to DONE with error, without waiting for the fall.
  - DONE: one cycle.
    - Good: `distance_mm` ← mm count, `dist_valid`=1.
    - Error: `distance_mm` ← MAX_MM, `dist_error`=1.
    - Then go to IDLE.
- Arithmetic:
  - `distance_mm` = floor(echo_µs / US_PER_MM), saturating at MAX_MM.
  - No divider; counter only.
- Reset (any state, any cycle):
  - State goes to IDLE. All counters clear. `period_due` is set, so the first trigger follows immediately after reset.
  - Output reset values: `sonartrigger`=0, `distance_mm`=0, `dist_valid`=0, `dist_error`=0, `busy`=0.
  - A measurement in flight is discarded with no strobe.

## Timing
- `sonartrigger` rises 1 cycle after entering TRIG and is high for exactly TRIG_US×CLK_FREQ/1e6 clocks (120 at default).
- Echo-to-count latency is 2 cycles, from the synchroniser. Both edges are delayed equally, so the width is preserved.
- Result strobe:
  - Appears 3 cycles after an echo fall at the pin, or 1 cycle after a MAX_MM or ECHO_WAIT_US expiry.
  - `dist_valid` and `dist_error` are never high together.
  - `busy` falls in the same cycle as the strobe.
- Simultaneous events:
  - Echo fall and MAX_MM reached in the same cycle: treat as good, reporting MAX_MM with `dist_valid`.
  - Echo rise and ECHO_WAIT_US expiry in the same cycle: the rise wins.
- Trigger period is PERIOD_MS ms ±1 ms tick, unless deferred.

## Structure
- `sonar_pkg` holds:
  - FSM state encodings (IDLE, TRIG, WAIT_ECHO, MEASURE, DONE).
  - Default constants: US_PER_MM, MAX_MM, ECHO_WAIT_US.
  - The derived `CLKS_PER_US` localparam function.
- Sub-module `us_tick_gen`:
  - Parameterised prescaler with synchronous clear.
  - Emits a 1-cycle µs pulse.
  - Instantiated once.
  - The ms divider stays inline.

## Test plan
- Reset then idle, no echo: `sonartrigger` pulses 120 clocks every 100 ms; `dist_error` strobes ~30 ms after each trigger fall; `distance_mm`=4000.
- Echo 450 µs after trigger fall, width 600 µs: `dist_valid` with `distance_mm`=100. Widths 4560/5160/7200/9000/5640 µs give 760/860/1200/1500/940.
- Echo width 30 ms (5000 mm): `dist_error` at 24 ms into the echo, `distance_mm`=4000; the late echo fall is ignored.
- Echo held high across the trigger: no measurement starts until low then high. Width 600 µs after a clean rise gives 100.
- `reset` asserted mid-MEASURE: all outputs return to reset values next cycle with no strobe; a new trigger follows immediately after `reset` deasserts.
- `PERIOD_MS`=10 with a 9 ms echo: the next trigger is deferred until after the DONE strobe, and exactly one trigger follows.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and defaults for the sonar ranging engine.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } state_e;

  localparam int unsigned DEF_US_PER_MM    = 6;
  localparam int unsigned DEF_MAX_MM       = 4000;
  localparam int unsigned DEF_ECHO_WAIT_US = 30_000;

  function automatic int unsigned clks_per_us(input int unsigned clk_freq);
    return clk_freq / 1_000_000;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Prescaler emitting a one-cycle pulse every DIV clocks; clr restarts the count.
module us_tick_gen #(
  parameter int unsigned DIV = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sonar_ranger.sv
// Ultrasonic ranging engine: periodic trigger, echo timing, width-to-mm conversion
// by counting, with a valid/error strobe per measurement.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned PERIOD_MS    = 100,
  parameter int unsigned US_PER_MM    = DEF_US_PER_MM,
  parameter int unsigned ECHO_WAIT_US = DEF_ECHO_WAIT_US,
  parameter int unsigned MAX_MM       = DEF_MAX_MM,
  parameter int unsigned DIST_W       = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sonarecho,
  output logic              sonartrigger,
  output logic [DIST_W-1:0] distance_mm,
  output logic              dist_valid,
  output logic              dist_error,
  output logic              busy
);

  localparam int unsigned CLKS_US = clks_per_us(CLK_FREQ);
  localparam int unsigned US_TOP  = (TRIG_US > ECHO_WAIT_US) ? TRIG_US : ECHO_WAIT_US;
  localparam int unsigned UW      = $clog2(US_TOP + 1);
  localparam int unsigned SW      = $clog2(US_PER_MM + 1);
  localparam int unsigned PW      = $clog2(PERIOD_MS + 1);

  localparam logic [UW-1:0]     TRIG_LAST = UW'(TRIG_US - 1);
  localparam logic [UW-1:0]     ECHO_LAST = UW'(ECHO_WAIT_US - 1);
  localparam logic [SW-1:0]     SUB_LAST  = SW'(US_PER_MM - 1);
  localparam logic [PW-1:0]     PER_LAST  = PW'(PERIOD_MS - 1);
  localparam logic [9:0]        MS_LAST   = 10'd999;
  localparam logic [DIST_W-1:0] MAX_D     = DIST_W'(MAX_MM);

  state_e            state_q, state_d;
  logic              echo_s1_q, echo_s2_q, echo_s3_q;
  logic [9:0]        ms_sub_q, ms_sub_d;
  logic [PW-1:0]     period_cnt_q, period_cnt_d;
  logic              period_due_q, period_due_d;
  logic [UW-1:0]     us_cnt_q, us_cnt_d;
  logic [SW-1:0]     mm_sub_q, mm_sub_d;
  logic [DIST_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic us_tick, us_clr, ms_wrap, period_wrap, echo_rise, echo_fall;

  us_tick_gen #(
    .DIV(CLKS_US)
  ) u_us_tick (
    .clock(clock),
    .reset(reset),
    .clr  (us_clr),
    .tick (us_tick)
  );

  assign echo_rise = echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q & echo_s3_q;

  always_comb begin
    ms_sub_d     = ms_sub_q;
    ms_wrap      = 1'b0;
    period_cnt_d = period_cnt_q;
    period_wrap  = 1'b0;
    if (us_tick) begin
      if (ms_sub_q == MS_LAST) begin
        ms_sub_d = '0;
        ms_wrap  = 1'b1;
      end else begin
        ms_sub_d = ms_sub_q + 1'b1;
      end
    end
    if (ms_wrap) begin
      if (period_cnt_q == PER_LAST) begin
        period_cnt_d = '0;
        period_wrap  = 1'b1;
      end else begin
        period_cnt_d = period_cnt_q + 1'b1;
      end
    end
    // A single pending flag: wraps while busy defer the trigger but never stack.
    period_due_d = period_due_q | period_wrap;

    state_d  = state_q;
    us_cnt_d = us_cnt_q;
    mm_sub_d = mm_sub_q;
    mm_cnt_d = mm_cnt_q;
    dist_d   = dist_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    us_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (period_due_q) begin
          state_d      = TRIG;
          period_due_d = 1'b0;
          us_clr       = 1'b1;
          us_cnt_d     = '0;
        end
      end
      TRIG: begin
        if (us_tick) begin
          if (us_cnt_q == TRIG_LAST) begin
            state_d  = WAIT_ECHO;
            us_cnt_d = '0;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_d  = MEASURE;
          us_clr   = 1'b1;
          mm_sub_d = '0;
          mm_cnt_d = '0;
        end else if (us_tick) begin
          if (us_cnt_q == ECHO_LAST) begin
            state_d = DONE;
            err_d   = 1'b1;
            dist_d  = MAX_D;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
      end
      MEASURE: begin
        if (us_tick) begin
          if (mm_sub_q == SUB_LAST) begin
            mm_sub_d = '0;
            mm_cnt_d = mm_cnt_q + 1'b1;
          end else begin
            mm_sub_d = mm_sub_q + 1'b1;
          end
        end
        // The tick landing on the fall cycle still counts, so a fall that
        // coincides with reaching MAX_MM reports a good MAX_MM result.
        if (echo_fall) begin
          state_d = DONE;
          valid_d = 1'b1;
          dist_d  = mm_cnt_d;
        end else if (mm_cnt_d == MAX_D) begin
          state_d = DONE;
          err_d   = 1'b1;
          dist_d  = MAX_D;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    trig_d = (state_d == TRIG);
    busy_d = (state_d == TRIG) || (state_d == WAIT_ECHO) || (state_d == MEASURE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      echo_s1_q    <= 1'b0;
      echo_s2_q    <= 1'b0;
      echo_s3_q    <= 1'b0;
      ms_sub_q     <= '0;
      period_cnt_q <= '0;
      period_due_q <= 1'b1;
      us_cnt_q     <= '0;
      mm_sub_q     <= '0;
      mm_cnt_q     <= '0;
      dist_q       <= '0;
      trig_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      echo_s1_q    <= sonarecho;
      echo_s2_q    <= echo_s1_q;
      echo_s3_q    <= echo_s2_q;
      ms_sub_q     <= ms_sub_d;
      period_cnt_q <= period_cnt_d;
      period_due_q <= period_due_d;
      us_cnt_q     <= us_cnt_d;
      mm_sub_q     <= mm_sub_d;
      mm_cnt_q     <= mm_cnt_d;
      dist_q       <= dist_d;
      trig_q       <= trig_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign sonartrigger = trig_q;
  assign distance_mm  = dist_q;
  assign dist_valid   = valid_q;
  assign dist_error   = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger, scaled to 2 MHz / 2 ms period / 200 mm range.
module tb_sonar_ranger;

  localparam int unsigned CLK_FREQ     = 2_000_000;
  localparam int unsigned TRIG_US      = 10;
  localparam int unsigned PERIOD_MS    = 2;
  localparam int unsigned US_PER_MM    = 6;
  localparam int unsigned ECHO_WAIT_US = 1000;
  localparam int unsigned MAX_MM       = 200;
  localparam int unsigned DIST_W       = 13;
  localparam int          CPU          = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              sonarecho = 1'b0;
  logic              sonartrigger, dist_valid, dist_error, busy;
  logic [DIST_W-1:0] distance_mm;

  always #5 clock = ~clock;

  sonar_ranger #(
    .CLK_FREQ    (CLK_FREQ),
    .TRIG_US     (TRIG_US),
    .PERIOD_MS   (PERIOD_MS),
    .US_PER_MM   (US_PER_MM),
    .ECHO_WAIT_US(ECHO_WAIT_US),
    .MAX_MM      (MAX_MM),
    .DIST_W      (DIST_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sonarecho   (sonarecho),
    .sonartrigger(sonartrigger),
    .distance_mm (distance_mm),
    .dist_valid  (dist_valid),
    .dist_error  (dist_error),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  // Event monitor, sampled on the falling edge.
  int   rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, trig_fall_cyc = 0, trig_width = 0;
  logic trig_prev = 1'b0;
  int   strobe_cnt = 0, s_cyc = 0, s_dist = 0, s_valid = 0, s_err = 0;
  int   both_cnt = 0, busy_strobe_cnt = 0;

  always @(negedge clock) begin
    if (sonartrigger === 1'b1 && trig_prev !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (sonartrigger === 1'b0 && trig_prev === 1'b1) begin
      fall_cnt++;
      trig_fall_cyc = cyc;
      trig_width = cyc - rise_cyc;
    end
    trig_prev = sonartrigger;
    if (dist_valid === 1'b1 || dist_error === 1'b1) begin
      strobe_cnt++;
      s_cyc   = cyc;
      s_dist  = int'(distance_mm);
      s_valid = (dist_valid === 1'b1) ? 1 : 0;
      s_err   = (dist_error === 1'b1) ? 1 : 0;
      if (dist_valid === 1'b1 && dist_error === 1'b1) both_cnt++;
      if (busy !== 1'b0) busy_strobe_cnt++;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      failed++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_trig_fall(input string name);
    int n0 = fall_cnt;
    int k = 0;
    while (fall_cnt == n0 && k < 12000) begin
      step();
      k++;
    end
    check({name, "_trig_seen"}, (fall_cnt != n0) ? 1 : 0, 1);
  endtask

  task automatic wait_strobe(input int s0, input string name);
    int k = 0;
    while (strobe_cnt == s0 && k < 6000) begin
      step();
      k++;
    end
    check({name, "_strobe_seen"}, (strobe_cnt != s0) ? 1 : 0, 1);
  endtask

  task automatic echo_pulse(input int delay_us, input int width_us,
                            output int e_rise, output int e_fall);
    repeat (delay_us * CPU) step();
    sonarecho = 1'b1;
    e_rise = cyc;
    repeat (width_us * CPU) step();
    sonarecho = 1'b0;
    e_fall = cyc;
  endtask

  typedef struct {
    string name;
    int    delay_us;   // negative: no echo at all
    int    width_us;
    int    exp_err;
    int    exp_dist;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int prev_rise = 0;
    int e_rise = 0, e_fall = 0;
    int s0, r0;

    vecs[0] = '{"w600",      450,  600, 0, 100};
    vecs[1] = '{"w599",      450,  599, 0,  99};
    vecs[2] = '{"w605",      450,  605, 0, 100};
    vecs[3] = '{"w1194",     200, 1194, 0, 199};
    vecs[4] = '{"w1200_max", 200, 1200, 0, 200};
    vecs[5] = '{"w1199",     100, 1199, 0, 199};
    vecs[6] = '{"overrange", 100, 1300, 1, 200};
    vecs[7] = '{"w6",         50,    6, 0,   1};
    vecs[8] = '{"w5",         50,    5, 0,   0};
    vecs[9] = '{"no_echo",    -1,    0, 1, 200};

    repeat (3) step();
    check("rst_trigger", int'(sonartrigger), 0);
    check("rst_distance", int'(distance_mm), 0);
    check("rst_valid", int'(dist_valid), 0);
    check("rst_error", int'(dist_error), 0);
    check("rst_busy", int'(busy), 0);

    r0 = rise_cnt;
    reset = 1'b0;
    step();
    step();
    check("first_trigger_after_reset", rise_cnt - r0, 1);

    for (int i = 0; i < 10; i++) begin
      wait_trig_fall(vecs[i].name);
      check({vecs[i].name, "_trig_width"}, trig_width, int'(TRIG_US) * CPU);
      if (i > 0) check_range({vecs[i].name, "_period"}, rise_cyc - prev_rise, 3990, 4020);
      prev_rise = rise_cyc;
      s0 = strobe_cnt;
      if (vecs[i].delay_us >= 0) echo_pulse(vecs[i].delay_us, vecs[i].width_us, e_rise, e_fall);
      wait_strobe(s0, vecs[i].name);
      repeat (10) step();
      check({vecs[i].name, "_strobes"}, strobe_cnt - s0, 1);
      check({vecs[i].name, "_valid"}, s_valid, 1 - vecs[i].exp_err);
      check({vecs[i].name, "_error"}, s_err, vecs[i].exp_err);
      check({vecs[i].name, "_dist"}, s_dist, vecs[i].exp_dist);
      check({vecs[i].name, "_dist_held"}, int'(distance_mm), vecs[i].exp_dist);
      if (vecs[i].delay_us < 0)
        check_range({vecs[i].name, "_latency"}, s_cyc - trig_fall_cyc, 1998, 2002);
      else if (vecs[i].exp_err != 0)
        check_range({vecs[i].name, "_latency"}, s_cyc - e_rise, 2400, 2404);
      else
        check({vecs[i].name, "_latency"}, s_cyc - e_fall, 3);
    end

    // Echo already high when the trigger ends must not start a measurement.
    r0 = rise_cnt;
    for (int k = 0; k < 12000 && rise_cnt == r0; k++) step();
    check("held_trig_seen", (rise_cnt != r0) ? 1 : 0, 1);
    sonarecho = 1'b1;
    wait_trig_fall("held");
    s0 = strobe_cnt;
    repeat (100 * CPU) step();
    sonarecho = 1'b0;
    echo_pulse(50, 600, e_rise, e_fall);
    wait_strobe(s0, "held");
    check("held_valid", s_valid, 1);
    check("held_dist", s_dist, 100);
    check("held_strobes", strobe_cnt - s0, 1);

    // Reset in the middle of a measurement.
    wait_trig_fall("rstmid");
    s0 = strobe_cnt;
    repeat (100 * CPU) step();
    sonarecho = 1'b1;
    repeat (300 * CPU) step();
    reset = 1'b1;
    step();
    check("rstmid_trigger", int'(sonartrigger), 0);
    check("rstmid_distance", int'(distance_mm), 0);
    check("rstmid_valid", int'(dist_valid), 0);
    check("rstmid_error", int'(dist_error), 0);
    check("rstmid_busy", int'(busy), 0);
    repeat (4) step();
    sonarecho = 1'b0;
    r0 = rise_cnt;
    reset = 1'b0;
    step();
    step();
    check("rstmid_retrigger", rise_cnt - r0, 1);
    check("rstmid_no_strobe", strobe_cnt - s0, 0);

    // Measurement outlasting the period: trigger deferred to after DONE.
    wait_trig_fall("defer");
    r0 = rise_cnt;
    s0 = strobe_cnt;
    echo_pulse(900, 1190, e_rise, e_fall);
    wait_strobe(s0, "defer");
    check("defer_valid", s_valid, 1);
    check("defer_dist", s_dist, 198);
    check("defer_no_trig_while_busy", rise_cnt - r0, 0);
    for (int k = 0; k < 20 && rise_cnt == r0; k++) step();
    check_range("defer_trig_after_done", rise_cyc - s_cyc, 1, 3);
    repeat (1500) step();
    check("defer_single_trigger", rise_cnt - r0, 1);

    check("never_both_strobes", both_cnt, 0);
    check("busy_low_at_strobe", busy_strobe_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
